// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: funct3 access encodings,
// the FSM state type and the funct3 legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    // Unsigned variants only exist for loads.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
        case (f3)
            F3_B, F3_H, F3_W: f3_illegal = 1'b0;
            F3_BU, F3_HU:     f3_illegal = is_store;
            default:          f3_illegal = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: store byte enables and replicated write data, and load
// byte/half selection with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_lane,
    input  logic        st_is_store,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be    = 4'b0000;
        st_wdata = st_data;
        case (st_funct3)
            F3_B: begin
                st_wdata = {4{st_data[7:0]}};
                if (st_is_store) st_be = 4'b0001 << st_lane;
            end
            F3_H: begin
                st_wdata = {2{st_data[15:0]}};
                if (st_is_store) st_be = st_lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                if (st_is_store) st_be = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_byte = ld_rdata[{ld_lane, 3'b000} +: 8];
        ld_half = ld_lane[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_BU:   ld_data = {24'h000000, ld_byte};
            F3_HU:   ld_data = {16'h0000, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: accepts a load or store from M, runs one
// valid/ready bus transaction while stalling the pipeline, returns formatted load data.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MemReadM,
    input  logic            MemWriteM,
    input  logic [2:0]      Funct3M,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    output logic            StallM,
    output logic [XLEN-1:0] ReadDataM,
    output logic            LoadValidM,
    output logic            MemFaultM,
    output logic            BusReq,
    output logic            BusWe,
    output logic [XLEN-1:0] BusAddr,
    output logic [XLEN-1:0] BusWData,
    output logic [3:0]      BusBE,
    input  logic            BusReady,
    input  logic [XLEN-1:0] BusRData
);

    lsu_state_e      state_q, state_d;
    logic            bus_req_q, bus_req_d;
    logic            bus_we_q, bus_we_d;
    logic [XLEN-1:0] bus_addr_q, bus_addr_d;
    logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]      bus_be_q, bus_be_d;
    logic [1:0]      lane_q, lane_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] read_data_q, read_data_d;
    logic            load_valid_q, load_valid_d;

    logic            req, is_store, misaligned, fault;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata, ld_data;

    lsu_align u_align (
        .st_funct3   (Funct3M),
        .st_lane     (ALUResultM[1:0]),
        .st_is_store (is_store),
        .st_data     (WriteDataM),
        .st_be       (st_be),
        .st_wdata    (st_wdata),
        .ld_funct3   (funct3_q),
        .ld_lane     (lane_q),
        .ld_rdata    (BusRData),
        .ld_data     (ld_data)
    );

    always_comb begin
        req        = MemReadM | MemWriteM;
        is_store   = MemWriteM;
        misaligned = ((Funct3M[1:0] == 2'b01) & ALUResultM[0])
                   | ((Funct3M[1:0] == 2'b10) & (ALUResultM[1:0] != 2'b00));
        fault      = req & (f3_illegal(Funct3M, is_store) | misaligned);
        MemFaultM  = (state_q == IDLE) & fault;
        StallM     = ((state_q == IDLE) & req & ~fault) | (state_q == REQ);
    end

    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_be_d     = bus_be_q;
        lane_d       = lane_q;
        funct3_d     = funct3_q;
        read_data_d  = read_data_q;
        load_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && !fault) begin
                    state_d     = REQ;
                    bus_req_d   = 1'b1;
                    bus_we_d    = is_store;
                    bus_addr_d  = {ALUResultM[XLEN-1:2], 2'b00};
                    bus_wdata_d = st_wdata;
                    bus_be_d    = st_be;
                    lane_d      = ALUResultM[1:0];
                    funct3_d    = Funct3M;
                end
            end
            REQ: begin
                if (BusReady) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        read_data_d  = ld_data;
                        load_valid_d = 1'b1;
                    end
                end
            end
            // M inputs still describe the retiring instruction here, so never re-accept.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_be_q     <= 4'b0000;
            lane_q       <= 2'b00;
            funct3_q     <= 3'b000;
            read_data_q  <= '0;
            load_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_be_q     <= bus_be_d;
            lane_q       <= lane_d;
            funct3_q     <= funct3_d;
            read_data_q  <= read_data_d;
            load_valid_q <= load_valid_d;
        end
    end

    assign BusReq     = bus_req_q;
    assign BusWe      = bus_we_q;
    assign BusAddr    = bus_addr_q;
    assign BusWData   = bus_wdata_q;
    assign BusBE      = bus_be_q;
    assign ReadDataM  = read_data_q;
    assign LoadValidM = load_valid_q;

endmodule
